crc8_frame_checker: RTL and testbench
=====================================

// Module: crc8_frame_checker
// PURPOSE
//  Receive-side partner of the serial CRC-8 generator (poly x^8+x^5+x^4+1, 0x31, init 0x00).
//  Accepts a bit-serial frame (PAYLOAD_BYTES data bytes MSB-first, then 8 CRC bits MSB-first).
//  Deserialises the payload bytes and checks the frame against its appended CRC.
//  Sits between the serial line front-end and the byte-oriented consumer logic.
// PARAMETERS
//  PAYLOAD_BYTES  4      payload bytes per frame (1..255)
//  POLY           8'h31  CRC-8 generator polynomial, implicit x^8
//  CRC_INIT       8'h00  LFSR value loaded at start of frame
// PORTS
//  clock       in   1  rising-edge clock
//  reset       in   1  asynchronous, active-high
//  rx_bit      in   1  serial data bit, sampled when rx_valid=1
//  rx_valid    in   1  rx_bit valid this cycle (one bit per cycle max, gaps allowed)
//  rx_sof      in   1  qualifies rx_bit as first bit of a frame (only meaningful with rx_valid)
//  data_out    out  8  last complete payload byte, first-received bit in [7]
//  data_valid  out  1  1-cycle strobe, data_out new
//  frame_done  out  1  1-cycle strobe, CRC field fully received
//  crc_ok      out  1  sticky: last frame residue == 0
//  crc_err     out  1  sticky: last frame residue != 0
//  busy        out  1  frame in progress (state != IDLE)
//  crc_value   out  8  running LFSR contents
// BEHAVIOUR
//  - Reset: state IDLE; data_out=0, crc_value=CRC_INIT; all 1-bit outputs 0. Takes effect mid-frame too.
//  - LFSR step per accepted bit: inv = rx_bit ^ crc[7]; crc <= {crc[6:0],1'b0} ^ (inv ? POLY : 8'h00).
//  - States: IDLE -> PAYLOAD -> CRCF -> IDLE.
//  - IDLE: rx_valid&rx_sof -> load CRC_INIT, apply step for this bit, shift it in, bit_cnt=1, clear
//    crc_ok/crc_err, go PAYLOAD. rx_valid without rx_sof: ignored.
//  - PAYLOAD: each rx_valid bit shifted into shift reg and stepped. When 8th bit of a byte accepted,
//    data_out and data_valid=1 on the next edge (1-cycle latency, strobe 1 cycle).
//    After PAYLOAD_BYTES*8 bits -> CRCF.
//  - CRCF: 8 bits, stepped through LFSR, not presented on data_out. After 8th bit, next edge:
//    frame_done=1 for 1 cycle; crc_ok=(next crc==0), crc_err=!crc_ok; go IDLE.
//  - Correct frame yields residue 0x00 (non-reflected, no final XOR).
//  - rx_valid=0: nothing changes; counters and LFSR hold.
//  - rx_sof&rx_valid while busy: abandon frame without frame_done/data_valid for the partial byte;
//    restart exactly as from IDLE using this bit.
//  - rx_sof without rx_valid: ignored.
//  - crc_ok/crc_err hold until next accepted sof or reset. Never both 1.
//  - Counters: bit_cnt 3b wraps 7->0; byte_cnt 8b; no overflow, since limited to PAYLOAD_BYTES.
// STRUCTURE
//  - crc_pkg: CRC8_POLY=8'h31, CRC8_INIT=8'h00, state encodings IDLE/PAYLOAD/CRCF.
//  - Sub-module crc8_serial_lfsr: enable, sync load of init value, parameterised POLY,
//    8-bit state output. Instantiated once.
//  - Top: FSM, bit/byte counters, shift register, output registers.
// TESTING
//  1. Frame 01 02 03 04 + CRC FE, rx_valid continuous -> data_valid x4 with 01,02,03,04;
//     frame_done, crc_ok=1, crc_value=00.
//  2. Same payload, CRC FF -> frame_done, crc_err=1, crc_ok=0.
//  3. Frame of test 1 with random 0-3 cycle rx_valid gaps -> identical bytes and crc_ok=1.
//  4. sof after 13 bits of a frame, then full test-1 frame -> no strobe for partial byte;
//     then 4 bytes and crc_ok=1.
//  5. reset asserted after byte 2 -> outputs 0, busy=0; then test-1 frame -> crc_ok=1.
//  6. Payload 00 00 00 00 + CRC 00 -> crc_ok=1; bits with rx_valid=1, rx_sof=0 while IDLE
//     -> no response.

Source files
------------

// File: rtl/crc8_frame_checker_pkg.sv
// crc8_frame_checker_pkg: shared constants, state encoding and LFSR step
// for the serial CRC-8 receive checker.
package crc8_frame_checker_pkg;

   localparam logic [7:0] CRC8_POLY = 8'h31;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CRCF    = 2'd2
   } state_t;

   // One MSB-first LFSR step, implicit x^8 term
   function automatic logic [7:0] crc8_step(
      input logic [7:0] crc,
      input logic       b,
      input logic [7:0] poly
   );
      logic inv;
      inv = b ^ crc[7];
      return {crc[6:0], 1'b0} ^ (inv ? poly : 8'h00);
   endfunction

endpackage

// File: rtl/crc8_frame_checker_if.sv
// crc8_frame_checker_if: serial receive input and byte/status outputs
// of the CRC-8 frame checker.
interface crc8_frame_checker_if;

   logic       rx_bit;
   logic       rx_valid;
   logic       rx_sof;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_done;
   logic       crc_ok;
   logic       crc_err;
   logic       busy;
   logic [7:0] crc_value;

   modport master (
      output rx_bit,
      output rx_valid,
      output rx_sof,
      input  data_out,
      input  data_valid,
      input  frame_done,
      input  crc_ok,
      input  crc_err,
      input  busy,
      input  crc_value
   );

   modport slave (
      input  rx_bit,
      input  rx_valid,
      input  rx_sof,
      output data_out,
      output data_valid,
      output frame_done,
      output crc_ok,
      output crc_err,
      output busy,
      output crc_value
   );

endinterface

// File: rtl/crc8_frame_checker_lfsr.sv
// crc8_frame_checker_lfsr: bit-serial CRC-8 LFSR with synchronous
// init load; crc_next exposes the value the register takes next edge.
module crc8_frame_checker_lfsr
   import crc8_frame_checker_pkg::*;
#(
   parameter logic [7:0] POLY = CRC8_POLY,
   parameter logic [7:0] INIT = CRC8_INIT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic       load,
   input  logic       bit_in,
   output logic [7:0] crc,
   output logic [7:0] crc_next
);

   logic [7:0] base;

   // Load selects the init value as the base the step is applied to
   always_comb begin
      base     = load ? INIT : crc;
      crc_next = en ? crc8_step(base, bit_in, POLY) : base;
   end

   // LFSR state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         crc <= INIT;
      end else begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker: deserialises a bit-serial frame, presents payload
// bytes and checks the appended CRC-8 residue.
module crc8_frame_checker
   import crc8_frame_checker_pkg::*;
#(
   parameter int         PAYLOAD_BYTES = 4,
   parameter logic [7:0] POLY          = CRC8_POLY,
   parameter logic [7:0] CRC_INIT      = CRC8_INIT
) (
   input logic                 clock,
   input logic                 reset,
   crc8_frame_checker_if.slave rx
);

   localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

   state_t     state;
   state_t     state_nx;
   logic [2:0] bit_cnt;
   logic [7:0] byte_cnt;
   logic [7:0] shreg;

   logic       acc;
   logic       sof;
   logic       lfsr_en;
   logic       lfsr_load;
   logic       byte_done;
   logic       last_byte;
   logic       frame_end;

   logic [7:0] crc;
   logic [7:0] crc_next;

   logic [7:0] data_out_q;
   logic       data_valid_q;
   logic       frame_done_q;
   logic       crc_ok_q;
   logic       crc_err_q;

   assign acc = rx.rx_valid;
   assign sof = rx.rx_valid & rx.rx_sof;

   crc8_frame_checker_lfsr #(
      .POLY (POLY),
      .INIT (CRC_INIT)
   ) u_lfsr (
      .clock    (clock),
      .reset    (reset),
      .en       (lfsr_en),
      .load     (lfsr_load),
      .bit_in   (rx.rx_bit),
      .crc      (crc),
      .crc_next (crc_next)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: a qualified sof always (re)starts a frame
   always_comb begin
      state_nx = state;
      if (sof) begin
         state_nx = PAYLOAD;
      end else begin
         unique case (state)
            IDLE:    state_nx = IDLE;
            PAYLOAD: if (last_byte) state_nx = CRCF;
            CRCF:    if (frame_end) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Control decode for the current accepted bit
   always_comb begin
      lfsr_load = sof;
      lfsr_en   = acc & (sof | (state != IDLE));
      byte_done = acc & ~sof & (state == PAYLOAD)
                & (bit_cnt == 3'd7);
      last_byte = byte_done & (byte_cnt == LAST_BYTE);
      frame_end = acc & ~sof & (state == CRCF)
                & (bit_cnt == 3'd7);
   end

   // Bit/byte counters and payload shift register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_cnt  <= 3'd0;
         byte_cnt <= 8'd0;
         shreg    <= 8'd0;
      end else if (sof) begin
         bit_cnt  <= 3'd1;
         byte_cnt <= 8'd0;
         shreg    <= {7'd0, rx.rx_bit};
      end else if (acc && state != IDLE) begin
         bit_cnt <= bit_cnt + 3'd1;
         shreg   <= {shreg[6:0], rx.rx_bit};
         if (last_byte) begin
            byte_cnt <= 8'd0;
         end else if (byte_done) begin
            byte_cnt <= byte_cnt + 8'd1;
         end
      end
   end

   // Byte/frame strobes and sticky CRC verdict
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_out_q   <= 8'd0;
         data_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         crc_err_q    <= 1'b0;
      end else begin
         data_valid_q <= byte_done;
         frame_done_q <= frame_end;
         if (byte_done) begin
            data_out_q <= {shreg[6:0], rx.rx_bit};
         end
         if (sof) begin
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
         end else if (frame_end) begin
            crc_ok_q  <= (crc_next == 8'd0);
            crc_err_q <= (crc_next != 8'd0);
         end
      end
   end

   assign rx.data_out   = data_out_q;
   assign rx.data_valid = data_valid_q;
   assign rx.frame_done = frame_done_q;
   assign rx.crc_ok     = crc_ok_q;
   assign rx.crc_err    = crc_err_q;
   assign rx.busy       = (state != IDLE);
   assign rx.crc_value  = crc;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb_crc8_frame_checker: directed frames with a byte/frame scoreboard
// checked against a bytewise CRC-8 reference.
module tb_crc8_frame_checker;

   typedef struct {
      logic       ok;
      logic [7:0] res;
   } frm_exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   crc8_frame_checker_if ifc ();

   crc8_frame_checker #(
      .PAYLOAD_BYTES (4),
      .POLY          (8'h31),
      .CRC_INIT      (8'h00)
   ) dut (
      .clock (clock),
      .reset (reset),
      .rx    (ifc)
   );

   logic [7:0] bq[$];
   frm_exp_t   fq[$];
   int errors   = 0;
   int checks   = 0;
   int dv_count = 0;
   int fd_count = 0;

   logic [7:0] mexp;
   frm_exp_t   mf;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_crc(input logic [7:0] b[5]);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < 5; i++) begin
         c = c ^ b[i];
         for (int j = 0; j < 8; j++)
            c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
      end
      return c;
   endfunction

   task automatic send_frame(input logic [7:0] f[5], input int nbits,
                             input bit gaps);
      logic [7:0] r;
      frm_exp_t   e;
      for (int k = 0; k < nbits; k++) begin
         if (gaps) begin
            ifc.rx_valid = 1'b0;
            ifc.rx_sof   = 1'($urandom_range(0, 1));
            ifc.rx_bit   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) begin
               @(posedge clock);
               #1;
            end
         end
         ifc.rx_valid = 1'b1;
         ifc.rx_sof   = (k == 0);
         ifc.rx_bit   = f[k/8][7-(k%8)];
         @(posedge clock);
         #1;
         if ((k % 8) == 7 && k < 32) bq.push_back(f[k/8]);
         if (k == 39) begin
            r     = model_crc(f);
            e.ok  = (r == 8'h00);
            e.res = r;
            fq.push_back(e);
         end
      end
      ifc.rx_valid = 1'b0;
      ifc.rx_sof   = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && (bq.size() != 0 || fq.size() != 0); i++)
         @(posedge clock);
      #1;
      chk({tag, "_bytes_left"}, 8'(bq.size()), 8'd0);
      chk({tag, "_frames_left"}, 8'(fq.size()), 8'd0);
   endtask

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clock) begin
      if (!reset && ifc.data_valid) begin
         dv_count++;
         if (bq.size() == 0) begin
            chk("data_valid_unexpected", 8'd1, 8'd0);
         end else begin
            mexp = bq.pop_front();
            chk("data_out", ifc.data_out, mexp);
         end
      end
      if (!reset && ifc.frame_done) begin
         fd_count++;
         if (fq.size() == 0) begin
            chk("frame_done_unexpected", 8'd1, 8'd0);
         end else begin
            mf = fq.pop_front();
            chk("crc_ok", 8'(ifc.crc_ok), 8'(mf.ok));
            chk("crc_err", 8'(ifc.crc_err), 8'(!mf.ok));
            chk("residue", ifc.crc_value, mf.res);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   logic [7:0] f1[5];
   logic [7:0] f2[5];
   logic [7:0] f0[5];
   int d0;
   int fd0;

   initial begin
      f1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFE};
      f2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
      f0 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      ifc.rx_bit   = 1'b0;
      ifc.rx_valid = 1'b0;
      ifc.rx_sof   = 1'b0;
      reset        = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_data_out", ifc.data_out, 8'h00);
      chk("rst_data_valid", 8'(ifc.data_valid), 8'd0);
      chk("rst_frame_done", 8'(ifc.frame_done), 8'd0);
      chk("rst_crc_ok", 8'(ifc.crc_ok), 8'd0);
      chk("rst_crc_err", 8'(ifc.crc_err), 8'd0);
      chk("rst_busy", 8'(ifc.busy), 8'd0);
      chk("rst_crc_value", ifc.crc_value, 8'h00);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // 1: good frame, continuous bits
      send_frame(f1, 40, 1'b0);
      drain("t1");
      chk("t1_strobes", 8'(dv_count), 8'd4);
      chk("t1_frames", 8'(fd_count), 8'd1);
      chk("t1_crc_ok_sticky", 8'(ifc.crc_ok), 8'd1);
      chk("t1_busy", 8'(ifc.busy), 8'd0);

      // 2: corrupted CRC byte
      send_frame(f2, 40, 1'b0);
      drain("t2");
      chk("t2_crc_err", 8'(ifc.crc_err), 8'd1);
      chk("t2_crc_ok", 8'(ifc.crc_ok), 8'd0);

      // 3: good frame with random idle gaps
      d0 = dv_count;
      send_frame(f1, 40, 1'b1);
      drain("t3");
      chk("t3_strobes", 8'(dv_count - d0), 8'd4);
      chk("t3_crc_ok", 8'(ifc.crc_ok), 8'd1);

      // 4: restart after 13 bits
      d0  = dv_count;
      fd0 = fd_count;
      send_frame(f1, 13, 1'b0);
      chk("t4_busy_partial", 8'(ifc.busy), 8'd1);
      send_frame(f1, 40, 1'b0);
      drain("t4");
      chk("t4_strobes", 8'(dv_count - d0), 8'd5);
      chk("t4_frames", 8'(fd_count - fd0), 8'd1);
      chk("t4_crc_ok", 8'(ifc.crc_ok), 8'd1);

      // 5: reset after byte 2
      send_frame(f1, 16, 1'b0);
      drain("t5a");
      reset = 1'b1;
      #2;
      chk("t5_rst_data_out", ifc.data_out, 8'h00);
      chk("t5_rst_busy", 8'(ifc.busy), 8'd0);
      chk("t5_rst_crc_ok", 8'(ifc.crc_ok), 8'd0);
      chk("t5_rst_crc_value", ifc.crc_value, 8'h00);
      @(posedge clock);
      #1;
      reset = 1'b0;
      send_frame(f1, 40, 1'b0);
      drain("t5b");
      chk("t5_crc_ok", 8'(ifc.crc_ok), 8'd1);

      // 6: all-zero frame, then unqualified bits while idle
      send_frame(f0, 40, 1'b0);
      drain("t6");
      chk("t6_crc_ok", 8'(ifc.crc_ok), 8'd1);
      d0 = dv_count;
      for (int i = 0; i < 16; i++) begin
         ifc.rx_valid = 1'b1;
         ifc.rx_sof   = 1'b0;
         ifc.rx_bit   = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
      end
      ifc.rx_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("t6_idle_busy", 8'(ifc.busy), 8'd0);
      chk("t6_idle_crc", ifc.crc_value, 8'h00);
      chk("t6_idle_strobes", 8'(dv_count - d0), 8'd0);
      chk("t6_idle_crc_ok", 8'(ifc.crc_ok), 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
